// File: rtl/demo.sv
// -----------------------------------------------------------------------------
// demo: registered 4:1 multiplexer.
//
// Steers one of four WIDTH-bit sources onto y with exactly one cycle of
// latency. The select index is {sa, sb}:
//   00 -> a, 01 -> b, 10 -> c, 11 -> d
// There is no enable and no handshake, so y reloads on every rising edge.
//
// Ports:
//   clk   in   1      system clock, rising edge
//   rst   in   1      asynchronous reset, active-high; clears y to zero at once
//   y     out  WIDTH  registered mux output
//   a..d  in   WIDTH  data inputs 0..3
//   sa    in   1      select MSB
//   sb    in   1      select LSB
// -----------------------------------------------------------------------------
module demo #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic             sa,
  input  logic             sb
);

  logic [1:0]       sel;
  logic [WIDTH-1:0] y_d;
  logic [WIDTH-1:0] y_q;

  assign sel = {sa, sb};

  // y_d is assigned before the case, so no path can leave it unassigned
  // and no latch is inferred.
  always_comb begin
    y_d = a;
    case (sel)
      2'b00:   y_d = a;
      2'b01:   y_d = b;
      2'b10:   y_d = c;
      2'b11:   y_d = d;
      default: y_d = a;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) y_q <= '0;
    else     y_q <= y_d;
  end

  assign y = y_q;

endmodule

// File: tb/tb_demo.sv
// -----------------------------------------------------------------------------
// tb_demo: self-checking bench for demo (WIDTH=8).
// Directed steps follow the block's intended behaviour, then a randomized run
// is checked against a behavioural model that picks the source by table lookup.
// -----------------------------------------------------------------------------
module tb_demo;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a, b, c, d, y;
  logic         sa, sb;

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_y;

  demo #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .y(y),
    .a(a), .b(b), .c(c), .d(d),
    .sa(sa), .sb(sb)
  );

  always #5 clk = ~clk;

  // Reference: the select index addresses a four-entry source table.
  function automatic logic [W-1:0] ref_mux(input logic [W-1:0] ia, ib, ic, id,
                                           input logic isa, isb);
    logic [W-1:0] src [4];
    src = '{ia, ib, ic, id};
    return src[{isa, isb}];
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic [W-1:0] ia, ib, ic, id, input logic isa, isb);
    a = ia; b = ib; c = ic; d = id; sa = isa; sb = isb;
  endtask

  // Capture what the next edge must load, then look 1 unit after that edge.
  task automatic edge_chk(input string tag);
    exp_y = ref_mux(a, b, c, d, sa, sb);
    @(posedge clk);
    #1;
    chk(tag, y, exp_y);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Power-up reset with all inputs high and sel=11.
    rst = 1'b1;
    drive(8'h01, 8'h01, 8'h01, 8'h01, 1'b1, 1'b1);
    #1;
    chk("reset_initial", y, 8'h00);
    @(posedge clk); #1;
    rst = 1'b0;
    edge_chk("first_load");

    // Assert reset between edges: immediate clear, held over three edges.
    #2;
    rst = 1'b1;
    #1;
    chk("reset_async", y, 8'h00);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("reset_hold", y, 8'h00);
    end
    rst = 1'b0;
    #1;
    chk("reset_release_no_edge", y, 8'h00);
    edge_chk("reset_release_load");

    // Select a, including one-cycle latency.
    drive(8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    edge_chk("sel_a_zero");
    a = 8'h01;
    #1;
    chk("sel_a_not_before_edge", y, 8'h00);
    edge_chk("sel_a_one");

    // Select b; a must be ignored.
    drive(8'h00, 8'h01, 8'h00, 8'h00, 1'b0, 1'b1);
    edge_chk("sel_b_one");
    drive(8'h01, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
    edge_chk("sel_b_ignore_a");

    // Select c and d.
    drive(8'h00, 8'h00, 8'h01, 8'h00, 1'b1, 1'b0);
    edge_chk("sel_c_one");
    drive(8'h00, 8'h00, 8'h00, 8'h01, 1'b1, 1'b1);
    edge_chk("sel_d_one");
    d = 8'h00;
    edge_chk("sel_d_zero");

    // Full-width walk through all four selects on consecutive edges.
    drive(8'h11, 8'h22, 8'h33, 8'h44, 1'b0, 1'b0);
    for (int s = 0; s < 4; s++) begin
      sa = s[1];
      sb = s[0];
      edge_chk($sformatf("walk_sel%0d", s));
    end

    // Mid-run reset pulse of half a cycle.
    drive(8'h11, 8'h22, 8'h33, 8'hFF, 1'b1, 1'b1);
    edge_chk("midrun_pre");
    chk("midrun_pre_value", y, 8'hFF);
    #2;
    rst = 1'b1;
    #1;
    chk("midrun_async_clear", y, 8'h00);
    #4;
    rst = 1'b0;
    chk("midrun_still_zero", y, 8'h00);
    edge_chk("midrun_reload");

    // Randomized run; unselected inputs glitch between edges.
    for (int i = 0; i < 200; i++) begin
      logic [1:0] s;
      s = 2'($urandom_range(0, 3));
      drive(W'($urandom), W'($urandom), W'($urandom), W'($urandom), s[1], s[0]);
      #2;
      if (s != 2'b00) a = W'($urandom);
      if (s != 2'b01) b = W'($urandom);
      if (s != 2'b10) c = W'($urandom);
      if (s != 2'b11) d = W'($urandom);
      edge_chk("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
